// File: rtl/led_display_sched_if.sv
// rtl/led_display_sched_if.sv - request/data/display bundle for led_display_sched
//
// Purpose: groups the requester side (req, src_data0..3, pin_en, pin_sel)
// and the display side (ack, disp_data, disp_src, disp_valid, busy) of the
// display scheduler so they travel as one port.
//   master : drives requests, source values and pin switches; observes display
//   slave  : the scheduler itself
interface led_display_sched_if;
  logic [3:0]  req;
  logic [31:0] src_data0;
  logic [31:0] src_data1;
  logic [31:0] src_data2;
  logic [31:0] src_data3;
  logic        pin_en;
  logic [1:0]  pin_sel;
  logic [3:0]  ack;
  logic [31:0] disp_data;
  logic [1:0]  disp_src;
  logic        disp_valid;
  logic        busy;

  modport master (
    output req, src_data0, src_data1, src_data2, src_data3, pin_en, pin_sel,
    input  ack, disp_data, disp_src, disp_valid, busy
  );

  modport slave (
    input  req, src_data0, src_data1, src_data2, src_data3, pin_en, pin_sel,
    output ack, disp_data, disp_src, disp_valid, busy
  );
endinterface

// File: rtl/led_display_sched.sv
// rtl/led_display_sched.sv - round-robin time-sharing of the seven-segment display
//
// Purpose: four requesters share the 32-bit display datapath. Each grant
// captures a snapshot of the winning source and holds it for DWELL_CYCLES
// clocks; a manual pin mode shows one selected source live.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : led_display_sched_if.slave
//           req[3:0]      level request per source
//           src_data0..3  source values
//           pin_en/pin_sel manual override switch and selected source
//           ack[3:0]      one-cycle capture pulse for the granted source
//           disp_data     value to the LED display
//           disp_src      index of the shown source
//           disp_valid    display holds a granted or pinned value
//           busy          high while showing or pinned
module led_display_sched #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_display_sched_if.slave    bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_PIN  = 2'd2;

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       src_q, src_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [3:0]       ack_q, ack_d;

  logic [31:0] src_arr [4];
  logic        gnt_found;
  logic [1:0]  gnt_idx;
  logic        take_grant;

  assign src_arr[0] = bus.src_data0;
  assign src_arr[1] = bus.src_data1;
  assign src_arr[2] = bus.src_data2;
  assign src_arr[3] = bus.src_data3;

  // Round-robin pick: scan last+1, last+2, last+3, last+4 (== last itself).
  // Walking the offsets from far to near lets the nearest requester overwrite.
  always_comb begin
    logic [1:0] idx;
    gnt_found = 1'b0;
    gnt_idx   = last_q + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (bus.req[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    data_d     = data_q;
    src_d      = src_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    ack_d      = 4'b0000;
    take_grant = 1'b0;

    if (bus.pin_en) begin
      // Pin has top priority: aborts any dwell and tracks the selected source live.
      state_d = ST_PIN;
      data_d  = src_arr[bus.pin_sel];
      src_d   = bus.pin_sel;
      valid_d = 1'b1;
      busy_d  = 1'b1;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_found) begin
            take_grant = 1'b1;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end
        end
        ST_SHOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (gnt_found) begin
            // Back-to-back re-grant: no IDLE bubble between dwells.
            take_grant = 1'b1;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end
        end
        ST_PIN: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end

    if (take_grant) begin
      state_d = ST_SHOW;
      data_d  = src_arr[gnt_idx];
      src_d   = gnt_idx;
      last_d  = gnt_idx;
      ack_d   = 4'b0001 << gnt_idx;
      cnt_d   = DWELL_LOAD;
      valid_d = 1'b1;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      data_q  <= '0;
      src_q   <= 2'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.disp_data  = data_q;
  assign bus.disp_src   = src_q;
  assign bus.disp_valid = valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_led_display_sched.sv
// tb/tb_led_display_sched.sv - self-checking bench for led_display_sched
module tb_led_display_sched;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  always #5 clk = ~clk;

  led_display_sched_if bus();

  led_display_sched #(.DWELL_CYCLES(D), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] src_of(input int k);
    case (k)
      0:       return bus.src_data0;
      1:       return bus.src_data1;
      2:       return bus.src_data2;
      default: return bus.src_data3;
    endcase
  endfunction

  // Reference model: mode 0=idle 1=showing 2=pinned; dwell tracked as the
  // cycle number of the last grant rather than a down-counter.
  int          m_mode = 0;
  int          m_cyc  = 0;
  int          m_gcyc = 0;
  int          m_last = 3;
  logic [31:0] e_data = '0;
  logic [1:0]  e_src  = '0;
  logic        e_valid = 1'b0;
  logic        e_busy  = 1'b0;
  logic [3:0]  e_ack   = '0;

  initial begin
    int  k;
    bit  found;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_cyc = 0; m_gcyc = 0; m_last = 3;
        e_data = '0; e_src = '0; e_valid = 1'b0; e_busy = 1'b0; e_ack = '0;
      end else begin
        m_cyc++;
        e_ack = '0;
        if (bus.pin_en) begin
          m_mode  = 2;
          e_data  = src_of(int'(bus.pin_sel));
          e_src   = bus.pin_sel;
          e_valid = 1'b1;
          e_busy  = 1'b1;
        end else if (m_mode == 2) begin
          m_mode = 0; e_valid = 1'b0; e_busy = 1'b0;
        end else if (m_mode == 0 || (m_cyc - m_gcyc) >= D) begin
          found = 1'b0;
          for (int off = 1; off <= 4; off++) begin
            k = (m_last + off) % 4;
            if (!found && bus.req[k]) begin
              found   = 1'b1;
              m_last  = k;
              e_data  = src_of(k);
              e_src   = 2'(k);
              e_ack   = 4'(1 << k);
              e_valid = 1'b1;
              e_busy  = 1'b1;
              m_mode  = 1;
              m_gcyc  = m_cyc;
            end
          end
          if (!found) begin
            m_mode = 0; e_valid = 1'b0; e_busy = 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        check("m_data",  bus.disp_data,          e_data);
        check("m_src",   32'(bus.disp_src),      32'(e_src));
        check("m_valid", 32'(bus.disp_valid),    32'(e_valid));
        check("m_busy",  32'(bus.busy),          32'(e_busy));
        check("m_ack",   32'(bus.ack),           32'(e_ack));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.req = 4'b0000;
    repeat (D + 1) tick();
  endtask

  logic [31:0] rr_data [5];
  logic [1:0]  rr_src  [5];
  int          n_ack;

  initial begin
    bus.req = '0; bus.pin_en = 1'b0; bus.pin_sel = '0;
    bus.src_data0 = '0; bus.src_data1 = '0; bus.src_data2 = '0; bus.src_data3 = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_data",  bus.disp_data,        32'h0);
    check("rst_valid", 32'(bus.disp_valid),  32'h0);
    check("rst_busy",  32'(bus.busy),        32'h0);
    check("rst_ack",   32'(bus.ack),         32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // First grant and dwell expiry.
    bus.src_data0 = 32'h12345678;
    bus.req = 4'b0001;
    tick();
    check("t1_data", bus.disp_data, 32'h12345678);
    check("t1_src",  32'(bus.disp_src), 32'h0);
    check("t1_ack",  32'(bus.ack), 32'h1);
    bus.req = 4'b0000;
    tick();
    check("t1_ack_pulse", 32'(bus.ack), 32'h0);
    tick(); tick();
    check("t1_valid_held", 32'(bus.disp_valid), 32'h1);
    tick();
    check("t1_valid_fall", 32'(bus.disp_valid), 32'h0);

    // Full round robin from a fresh reset.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    bus.src_data0 = 32'h00000000; bus.src_data1 = 32'h10101010;
    bus.src_data2 = 32'h20202020; bus.src_data3 = 32'h30303030;
    rr_src[0] = 2'd0; rr_src[1] = 2'd1; rr_src[2] = 2'd2; rr_src[3] = 2'd3; rr_src[4] = 2'd0;
    rr_data[0] = 32'h00000000; rr_data[1] = 32'h10101010; rr_data[2] = 32'h20202020;
    rr_data[3] = 32'h30303030; rr_data[4] = 32'h00000000;
    bus.req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      if (g > 0) repeat (D) tick();
      check("rr_src",  32'(bus.disp_src), 32'(rr_src[g]));
      check("rr_data", bus.disp_data, rr_data[g]);
      check("rr_ack",  32'(bus.ack), 32'(4'b0001 << rr_src[g]));
    end

    // Single requester with a moving source: one ack every D cycles.
    go_idle();
    bus.req = 4'b0100;
    n_ack = 0;
    for (int c = 0; c < 3 * D; c++) begin
      bus.src_data2 = bus.src_data2 + 32'd1;
      tick();
      if (bus.ack != 4'b0000) n_ack++;
    end
    check("single_acks", 32'(n_ack), 32'd3);

    // Pin aborting a dwell of source 1.
    go_idle();
    bus.req = 4'b0010;
    tick();
    check("pin_pre_src", 32'(bus.disp_src), 32'h1);
    tick();
    bus.pin_en = 1'b1; bus.pin_sel = 2'd3;
    tick();
    check("pin_src", 32'(bus.disp_src), 32'h3);
    check("pin_ack", 32'(bus.ack), 32'h0);
    bus.src_data3 = 32'hDEADBEEF;
    tick();
    check("pin_live", bus.disp_data, 32'hDEADBEEF);
    bus.pin_en = 1'b0; bus.req = 4'b0011;
    tick();
    check("pin_exit_valid", 32'(bus.disp_valid), 32'h0);
    tick();
    check("pin_regrant_src", 32'(bus.disp_src), 32'h0);
    check("pin_regrant_ack", 32'(bus.ack), 32'h1);

    // Same-edge pin and request from idle.
    go_idle();
    bus.pin_en = 1'b1; bus.pin_sel = 2'd0; bus.req = 4'b1000;
    tick();
    check("same_busy", 32'(bus.busy), 32'h1);
    check("same_ack",  32'(bus.ack), 32'h0);
    bus.pin_en = 1'b0;
    tick();
    tick();
    check("same_after_src", 32'(bus.disp_src), 32'h3);
    check("same_after_ack", 32'(bus.ack), 32'h8);

    // Asynchronous reset mid-dwell.
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_data",  bus.disp_data, 32'h0);
    check("arst_valid", 32'(bus.disp_valid), 32'h0);
    check("arst_busy",  32'(bus.busy), 32'h0);
    tick();
    bus.req = 4'b1010;
    rst_n = 1'b1;
    tick();
    check("arst_first_src", 32'(bus.disp_src), 32'h1);
    check("arst_first_ack", 32'(bus.ack), 32'h2);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.pin_en = ~bus.pin_en;
      if ($urandom_range(0, 3) == 0) bus.pin_sel = 2'($urandom_range(0, 3));
      bus.src_data0 = $urandom();
      bus.src_data1 = $urandom();
      bus.src_data2 = $urandom();
      bus.src_data3 = $urandom();
      tick();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
